// File: rtl/afx_axis_pkg.sv
// Shared types and helpers for the AXI-Stream round-robin arbiter.
// rr_pick implements the double-width masked priority search used by afx_rr_arb.
package afx_axis_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int MAX_SRC = 16;
  localparam int MAX_IDW = 4;

  typedef struct packed {
    logic [MAX_SRC-1:0] onehot;
    logic [MAX_IDW-1:0] idx;
  } rr_pick_t;

  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Requests are duplicated side by side; bits at or below ptr are masked, so the
  // lowest surviving bit is the first requester after ptr, wrapping modulo n.
  function automatic rr_pick_t rr_pick(input logic [MAX_SRC-1:0] req,
                                       input logic [MAX_IDW-1:0] ptr,
                                       input int n);
    logic [2*MAX_SRC-1:0] dbl;
    logic [2*MAX_SRC-1:0] masked;
    rr_pick_t res;
    int hit;
    int sel;
    res    = '0;
    dbl    = '0;
    masked = '0;
    hit    = -1;
    sel    = 0;
    for (int j = 0; j < 2*MAX_SRC; j++) begin
      if (j < n) begin
        dbl[j] = req[j];
      end else if (j < 2*n) begin
        dbl[j] = req[j-n];
      end else begin
        dbl[j] = 1'b0;
      end
      masked[j] = dbl[j] && (j > int'(ptr));
    end
    for (int j = 2*MAX_SRC-1; j >= 0; j--) begin
      if (masked[j]) begin
        hit = j;
      end else begin
        hit = hit;
      end
    end
    if (hit >= 0) begin
      sel = (hit >= n) ? (hit - n) : hit;
      res.idx = MAX_IDW'(sel);
      res.onehot[sel] = 1'b1;
    end else begin
      res = '0;
    end
    return res;
  endfunction

endpackage

// File: rtl/afx_rr_arb.sv
// Combinational round-robin picker: first asserted request after ptr, modulo NUM_SRC.
module afx_rr_arb
  import afx_axis_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = id_width(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [ID_W-1:0]    o_gnt_idx,
  output logic               o_gnt_vld
);

  rr_pick_t           w_pick;
  logic [MAX_SRC-1:0] w_req_ext;
  logic [MAX_IDW-1:0] w_ptr_ext;

  assign w_req_ext = MAX_SRC'(i_req);
  assign w_ptr_ext = MAX_IDW'(i_ptr);
  assign w_pick    = rr_pick(w_req_ext, w_ptr_ext, NUM_SRC);
  assign o_gnt_idx = ID_W'(w_pick.idx);
  // A winner is only reported when its index is a real source.
  assign o_gnt_vld = (|w_pick.onehot) && ({1'b0, w_pick.idx} < 5'(NUM_SRC));

endmodule

// File: rtl/afx_axis_rr_arbiter.sv
// N:1 AXI-Stream round-robin arbiter with packet lock and a registered output stage
// carrying data, last and source ID.
module afx_axis_rr_arbiter
  import afx_axis_pkg::*;
#(
  parameter int NUM_SRC  = 4,
  parameter int DATA_W   = 32,
  parameter bit LOCK_PKT = 1'b1,
  parameter int ID_W     = id_width(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*DATA_W-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]        s_axis_tvalid,
  input  logic [NUM_SRC-1:0]        s_axis_tlast,
  output logic [NUM_SRC-1:0]        s_axis_tready,
  output logic [DATA_W-1:0]         m_axis_tdata,
  output logic                      m_axis_tvalid,
  output logic                      m_axis_tlast,
  output logic [ID_W-1:0]           m_axis_tid,
  input  logic                      m_axis_tready
);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic [ID_W-1:0]   r_grant;
  logic [ID_W-1:0]   w_grant_nxt;
  logic [ID_W-1:0]   r_ptr;
  logic [ID_W-1:0]   w_ptr_nxt;
  logic [ID_W-1:0]   w_pick_idx;
  logic              w_pick_vld;
  logic              w_ld;
  logic              w_accept;
  logic              w_sel_last;
  logic [DATA_W-1:0] w_sel_data;
  logic [DATA_W-1:0] r_tdata;
  logic              r_tvalid;
  logic              r_tlast;
  logic [ID_W-1:0]   r_tid;

  afx_rr_arb #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_rr_arb (
    .i_req     (s_axis_tvalid),
    .i_ptr     (r_ptr),
    .o_gnt_idx (w_pick_idx),
    .o_gnt_vld (w_pick_vld)
  );

  assign w_ld       = !r_tvalid || m_axis_tready;
  assign w_sel_data = s_axis_tdata[r_grant*DATA_W +: DATA_W];
  assign w_sel_last = s_axis_tlast[r_grant];
  assign w_accept   = s_axis_tvalid[r_grant] && s_axis_tready[r_grant];

  // Ready goes only to the granted source, and only when the output register can load.
  always_comb begin
    s_axis_tready = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if ((r_state == BUSY) && (r_grant == ID_W'(i)) && w_ld && !rst) begin
        s_axis_tready[i] = 1'b1;
      end else begin
        s_axis_tready[i] = 1'b0;
      end
    end
  end

  // Next state: arbitrate in IDLE, release the grant on the closing accept in BUSY.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      IDLE: begin
        if (w_pick_vld) begin
          w_state_nxt = BUSY;
          w_grant_nxt = w_pick_idx;
          w_ptr_nxt   = w_pick_idx;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      BUSY: begin
        if (w_accept && (!LOCK_PKT || w_sel_last)) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = BUSY;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Arbitration state; ptr restarts at the last source so source 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_ptr   <= ID_W'(NUM_SRC - 1);
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Output register holds its beat while the downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
      r_tlast  <= 1'b0;
      r_tid    <= '0;
    end else if (w_accept) begin
      r_tvalid <= 1'b1;
      r_tdata  <= w_sel_data;
      r_tlast  <= w_sel_last;
      r_tid    <= r_grant;
    end else if (w_ld) begin
      r_tvalid <= 1'b0;
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tid    = r_tid;

endmodule

// File: doc/afx_axis_rr_arbiter.md
Name: afx_axis_rr_arbiter

Overview:
- N-input to 1-output AXI-Stream arbiter. Shares one downstream stream (typically a skid-buffer input) among NUM_SRC requesters.
- Arbitration is round-robin. A grant is held for a whole packet, through the beat with tlast; with LOCK_PKT=0 the grant is held for a single beat.
- Output stage is a registered pipeline stage carrying data, last and source ID.
- Sits in front of the shared SATA transport-layer FIFO/skid path.

Parameters:
- NUM_SRC, 4: number of upstream sources; range 2..16.
- DATA_W, 32: tdata width in bits.
- LOCK_PKT, 1: 1 = hold grant until tlast is accepted; 0 = re-arbitrate after every beat.
- ID_W, $clog2(NUM_SRC): width of m_axis_tid.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- s_axis_tdata  in  NUM_SRC*DATA_W  source data; source i occupies bits [i*DATA_W +: DATA_W]
- s_axis_tvalid  in  NUM_SRC  per-source valid
- s_axis_tlast  in  NUM_SRC  per-source end-of-packet
- s_axis_tready  out  NUM_SRC  per-source ready
- m_axis_tdata  out  DATA_W  output data (registered)
- m_axis_tvalid  out  1  output valid (registered)
- m_axis_tlast  out  1  output last (registered)
- m_axis_tid  out  ID_W  index of the source that produced the beat (registered)
- m_axis_tready  in  1  downstream ready

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, grant=0, ptr=NUM_SRC-1, so source 0 has highest priority after reset.
  - m_axis_tvalid=0, tdata=0, tlast=0, tid=0.
  - s_axis_tready=0.
  - Reset mid-packet abandons the packet and clears the output register; no beat is emitted after reset.
- States:
  - IDLE: no grant; arbitrate.
  - BUSY: grant held; transfer beats from the granted source.
- IDLE, no tvalid asserted: stay in IDLE.
- IDLE, any tvalid asserted: the winner is the first asserted source scanning ptr+1, ptr+2, ... modulo NUM_SRC. Register grant=winner and ptr=winner, then go to BUSY.
  - Arbitration therefore costs exactly 1 bubble cycle per grant.
- Output-register enable: ld = !m_axis_tvalid || m_axis_tready.
- s_axis_tready[i] = (state==BUSY) && (grant==i) && ld. It is 0 for every other source and in IDLE.
  - This is the only combinational path from m_axis_tready to s_axis_tready.
- Accept = s_axis_tvalid[grant] && s_axis_tready[grant]. On accept, load m_axis_tdata/tlast from the granted source, load tid=grant, set m_axis_tvalid=1.
  - Latency: 1 cycle from accept to appearance at the output.
- If ld=1 and there is no accept, clear m_axis_tvalid to 0.
- While m_axis_tvalid=1 and m_axis_tready=0, hold m_axis_tdata/tlast/tid/tvalid stable (AXI rule).
- Return from BUSY to IDLE in the same cycle as:
  - accept with tlast=1 (LOCK_PKT=1), or
  - any accept (LOCK_PKT=0).
- A granted source that drops tvalid mid-packet keeps the grant; other sources wait (no timeout).
- Simultaneous requests: the round-robin order is strictly enforced. A source just served has the lowest priority at the next arbitration.
- Sources not granted never see tready=1, so their valid/data must stay asserted (upstream AXI rule).
- Throughput: 1 beat/clk while granted and downstream ready. Per packet: payload beats + 1 arbitration cycle.
- ptr updates only on grant, never on reset release or in idle cycles.

Decomposition:
- Package afx_axis_pkg:
  - state enum arb_state_e {IDLE, BUSY}.
  - function rr_pick(req, ptr) returning a one-hot vector and an index.
  - localparam helper for ID_W.
- Sub-module afx_rr_arb: purely combinational round-robin picker.
  - Inputs: req[NUM_SRC], ptr.
  - Outputs: gnt_idx, gnt_vld.
  - Implemented by the double-width masked priority method.
- Top module holds the FSM, grant/ptr registers, data mux and output register.

Test Plan:
1. Reset priority, NUM_SRC=4: all four sources valid, each with a 1-beat packet of data 0xA0..0xA3 -> output tid order 0,1,2,3. Each beat appears 2 cycles after it is requested (1 arbitration + 1 register), with one bubble between beats.
2. Packet lock: src1 sends 3 beats (0x11,0x12,0x13 with tlast on 0x13) while src2 is valid throughout -> src2's tready stays 0 until the 0x13 accept. Output is 0x11,0x12,0x13 with tid=1, then src2's packet with tid=2.
3. Backpressure: hold m_axis_tready=0 for 5 cycles mid-packet -> output data/tid/tlast stay stable and s_axis_tready[grant]=0. Resume with no lost or duplicated beat.
4. Fairness: src0 and src3 continuously valid with 2-beat packets -> grants alternate 0,3,0,3. Over 8 packets the grant count is exactly 4/4.
5. Synchronous reset mid-packet: assert rst on beat 2 of a 4-beat packet from src2 -> the next cycle shows m_axis_tvalid=0 and all readies 0. The first grant after release goes to the lowest-indexed requester.
6. LOCK_PKT=0: src0 and src1 continuously valid with tlast=0 -> tid alternates 0,1,0,1 beat by beat.
